// File: rtl/unary_pkg.sv
// Shared definitions for the unary window counter.
//   state_t : measurement FSM states (IDLE, RUN)
//   cw_of   : count width needed to hold 0..window inclusive
package unary_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int unsigned cw_of(input int unsigned window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/unary_ch_acc.sv
// Per-channel accumulator and result decode for one unary bitstream.
//   clock     : rising-edge clock
//   reset     : synchronous active-high reset, zeroes the accumulator
//   clr_i     : zero the accumulator (start, window restart, abort)
//   en_i      : accumulate bit_i this cycle
//   bit_i     : unary stream bit
//   bipolar_i : select bipolar decode of the result
//   result_o  : decoded count including the current bit_i (CW+1 bits)
module unary_ch_acc
    import unary_pkg::*;
#(
    parameter  int unsigned WINDOW = 128,
    localparam int unsigned CW     = cw_of(WINDOW)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        bit_i,
    input  logic        bipolar_i,
    output logic [CW:0] result_o
);

    localparam logic [CW:0] WIN_V = (CW + 1)'(WINDOW);

    logic [CW-1:0] acc_q;
    logic [CW-1:0] acc_d;
    logic [CW-1:0] final_cnt;

    // Count including this cycle's bit, so the top can capture the result
    // on the same edge that the last sample of the window arrives.
    always_comb begin
        final_cnt = acc_q + CW'(bit_i);
        acc_d     = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = final_cnt;
        end
    end

    // Bipolar: 2*count - WINDOW; fits in CW+1 bits since WINDOW < 2**CW.
    always_comb begin
        if (bipolar_i) begin
            result_o = {final_cnt, 1'b0} - WIN_V;
        end else begin
            result_o = {1'b0, final_cnt};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/unary_window_counter.sv
// Multi-channel unary bitstream window counter.
// Counts ones per channel over WINDOW valid samples and presents a signed
// per-channel result through a valid/ready output register.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   io_in, io_in_valid  : one stream bit per channel plus sample qualifier
//   io_start, io_stop   : begin (IDLE only) / abort (RUN only) measurement
//   io_continuous       : back-to-back windows, latched at start
//   io_bipolar          : bipolar decode, latched at start
//   io_clear            : clears the sticky overrun flag
//   io_out_count        : NCH x (CW+1)-bit results, channel 0 in LSBs
//   io_out_valid/ready  : result handshake
//   io_busy             : measurement in progress
//   io_overrun          : sticky, an unconsumed result was overwritten
module unary_window_counter
    import unary_pkg::*;
#(
    parameter  int unsigned NCH    = 4,
    parameter  int unsigned WINDOW = 128,
    localparam int unsigned CW     = cw_of(WINDOW)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NCH-1:0]        io_in,
    input  logic                  io_in_valid,
    input  logic                  io_start,
    input  logic                  io_stop,
    input  logic                  io_continuous,
    input  logic                  io_bipolar,
    input  logic                  io_clear,
    output logic [NCH*(CW+1)-1:0] io_out_count,
    output logic                  io_out_valid,
    input  logic                  io_out_ready,
    output logic                  io_busy,
    output logic                  io_overrun
);

    localparam logic [CW-1:0] LAST_IDX = CW'(WINDOW - 1);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    cont_q, cont_d;
    logic                    bip_q, bip_d;
    logic [NCH*(CW+1)-1:0]   res_q, res_d;
    logic                    valid_q, valid_d;
    logic                    ovr_q, ovr_d;
    logic [NCH*(CW+1)-1:0]   res_w;

    logic start_go;
    logic abort;
    logic sample;
    logic done;
    logic acc_clr;

    always_comb begin
        start_go = (state_q == IDLE) && io_start;
        abort    = (state_q == RUN) && io_stop;
        // Abort takes priority, so a stop on the last sample produces nothing.
        sample   = (state_q == RUN) && io_in_valid && !io_stop;
        done     = sample && (cnt_q == LAST_IDX);
        acc_clr  = start_go || abort || done;
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        unary_ch_acc #(
            .WINDOW(WINDOW)
        ) u_acc (
            .clock    (clock),
            .reset    (reset),
            .clr_i    (acc_clr),
            .en_i     (sample),
            .bit_i    (io_in[c]),
            .bipolar_i(bip_q),
            .result_o (res_w[c*(CW+1) +: (CW+1)])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cont_d  = cont_q;
        bip_d   = bip_q;
        res_d   = res_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (start_go) begin
            state_d = RUN;
            cnt_d   = '0;
            cont_d  = io_continuous;
            bip_d   = io_bipolar;
        end else if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (done) begin
            cnt_d = '0;
            if (!cont_q) begin
                state_d = IDLE;
            end
        end else if (sample) begin
            cnt_d = cnt_q + CW'(1);
        end

        // A load wins over a same-cycle transfer, keeping valid high.
        if (done) begin
            res_d   = res_w;
            valid_d = 1'b1;
        end else if (valid_q && io_out_ready) begin
            valid_d = 1'b0;
        end

        // Overrun event wins over a same-cycle clear.
        if (done && valid_q && !io_out_ready) begin
            ovr_d = 1'b1;
        end else if (io_clear) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cont_q  <= 1'b0;
            bip_q   <= 1'b0;
            res_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cont_q  <= cont_d;
            bip_q   <= bip_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign io_out_count = res_q;
    assign io_out_valid = valid_q;
    assign io_busy      = (state_q == RUN);
    assign io_overrun   = ovr_q;

endmodule

// File: doc/unary_window_counter.md
UNARY_WINDOW_COUNTER -- requirements
Module: unary_window_counter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NCH, 4, number of unary bitstream channels
- WINDOW, 128, valid samples per measurement window (2..65535)
- CW = clog2(WINDOW+1), derived, count width
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clock, in, 1, sole clock, rising edge
- reset, in, 1, synchronous active-high reset
- io_in, in, NCH, one unary stream bit per channel
- io_in_valid, in, 1, io_in sample qualifier
- io_start, in, 1, begin measurement (IDLE only)
- io_stop, in, 1, abort measurement
- io_continuous, in, 1, back-to-back windows; sampled at start
- io_bipolar, in, 1, bipolar decode; sampled at start
- io_clear, in, 1, clears io_overrun
- io_out_count, out, NCH*(CW+1), per-channel signed result, channel 0 in LSBs
- io_out_valid, out, 1, result available
- io_out_ready, in, 1, consumer accepts result
- io_busy, out, 1, measurement in progress
- io_overrun, out, 1, sticky: unconsumed result was overwritten

Function
REQ-003 FSM SHALL have states IDLE and RUN; io_busy SHALL be 1 exactly in RUN.
REQ-004 IDLE with io_start=1 SHALL enter RUN next cycle, zero all accumulators and the sample counter, and latch io_continuous and io_bipolar.
REQ-005 io_start in RUN SHALL be ignored.
REQ-006 In RUN, each cycle with io_in_valid=1 SHALL add io_in[c] to acc[c] and increment the sample counter; cycles with io_in_valid=0 SHALL change nothing.
REQ-007 When the sample counter equals WINDOW-1 and io_in_valid=1, the window completes: the result register SHALL load the final counts (including that sample), and io_out_valid SHALL be 1 next cycle.
REQ-008 Unipolar result SHALL be count zero-extended to CW+1 bits; bipolar result SHALL be 2*count-WINDOW in CW+1-bit two's complement.
REQ-009 On completion with continuous latched, FSM SHALL stay in RUN with accumulators and counter restarted, losing no sample; otherwise it SHALL return to IDLE.
REQ-010 io_out_valid SHALL stay 1 and io_out_count SHALL stay stable until io_out_valid & io_out_ready; that transfer clears io_out_valid next cycle unless a new result loads the same cycle.
REQ-011 New result while io_out_valid=1 and io_out_ready=0 SHALL overwrite the register, keep io_out_valid=1, and set io_overrun.
REQ-012 New result in the same cycle as a transfer SHALL load with io_out_valid held at 1 and no overrun.
REQ-013 io_stop in RUN SHALL return to IDLE next cycle and discard the partial window; io_stop SHALL win over a same-cycle completion (no result produced).
REQ-014 io_stop in IDLE SHALL be ignored; a pending result SHALL survive io_stop.
REQ-015 io_clear SHALL clear io_overrun next cycle; a same-cycle overrun event SHALL win (flag stays 1).
REQ-016 Latency from the final valid sample to io_out_valid SHALL be exactly 1 cycle.

Reset
REQ-017 Reset SHALL force IDLE and zero the accumulators, sample counter, io_out_count, io_out_valid, io_busy and io_overrun; it SHALL override every other input, including mid-window.

Structure
REQ-018 State enum and the CW width function SHALL live in shared package unary_pkg.
REQ-019 The per-channel accumulator-and-decode SHALL be sub-module unary_ch_acc, instantiated NCH times.

Verification (NCH=2, WINDOW=128)
REQ-020 ch0=1 constantly, ch1 alternating 1/0, valid always, unipolar -> io_out_valid 129 cycles after start; counts 128 and 64.
REQ-021 Bipolar with ch0 all 1, ch1 all 0 -> +128 and -128; ch0 alternating -> 0.
REQ-022 io_in_valid low every other cycle -> result only after 256 RUN cycles; counts equal REQ-020.
REQ-023 Continuous mode, ready held 0 for two windows -> second result visible, io_overrun=1; io_clear -> 0; ready=1 throughout -> no gaps, io_overrun stays 0.
REQ-024 io_stop at sample 100, and io_stop coincident with sample 127 -> IDLE, no io_out_valid; reset at sample 60 -> all outputs 0 next cycle.
